data_memory_read_interface: RTL and testbench

Load-side companion to the store byte-enable/shift path in stage 4. Drives the word address of the synchronous-read data memory and turns the returned word(s) into the architectural load result.
- Byte select, then sign or zero extension per RISC-V funct3.
- Loads that straddle a word boundary become a two-beat read. The unit stalls upstream while the second beat is in flight.
- Sits between the stage-4 address/control inputs and the stage-5 writeback register.

---
 rtl/data_memory_read_interface_pkg.sv | 27 ++
 rtl/data_memory_read_interface_load_extract.sv | 25 ++
 rtl/data_memory_read_interface.sv | 105 ++++++++++
 tb/tb_data_memory_read_interface.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_read_interface_pkg.sv
// Shared load-path definitions: funct3 load encodings, decode index and read FSM states.
package data_memory_read_interface_pkg;

   localparam logic [2:0] LOAD_B  = 3'b000;
   localparam logic [2:0] LOAD_H  = 3'b001;
   localparam logic [2:0] LOAD_W  = 3'b010;
   localparam logic [2:0] LOAD_BU = 3'b100;
   localparam logic [2:0] LOAD_HU = 3'b101;

   localparam int DO_LOAD = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT1 = 2'b01,
      BEAT2 = 2'b10
   } rd_state_t;

   // A load needs a second word when its bytes run past byte 3 of the first word.
   function automatic logic is_split_load(input logic [2:0] load_type, input logic [1:0] offset);
      case (load_type)
         LOAD_B, LOAD_BU: is_split_load = 1'b0;
         LOAD_H, LOAD_HU: is_split_load = (offset == 2'd3);
         default:         is_split_load = (offset != 2'd0);
      endcase
   endfunction

endpackage

// File: rtl/data_memory_read_interface_load_extract.sv
// Byte selection and sign/zero extension of a load from an 8-byte window.
module load_extract
   import data_memory_read_interface_pkg::*;
(
   input  logic [63:0] window,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_type,
   output logic [31:0] result
);

   logic [31:0] shifted_s;

   // Align the addressed byte to bit 0, then extend to the load width.
   always_comb begin
      shifted_s = 32'(window >> {offset, 3'b000});
      case (load_type)
         LOAD_B:  result = {{24{shifted_s[7]}}, shifted_s[7:0]};
         LOAD_BU: result = {24'h000000, shifted_s[7:0]};
         LOAD_H:  result = {{16{shifted_s[15]}}, shifted_s[15:0]};
         LOAD_HU: result = {16'h0000, shifted_s[15:0]};
         default: result = shifted_s;
      endcase
   end

endmodule

// File: rtl/data_memory_read_interface.sv
// Load-side data memory interface: drives word address, merges split beats, extends the result.
module data_memory_read_interface
   import data_memory_read_interface_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 30
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              valid,
   input  logic              instr_is_load,
   input  logic [ADDR_W-1:0] long_addr,
   input  logic [2:0]        load_type,
   output logic [MEM_AW-1:0] mem_word_addr,
   input  logic [31:0]       mem_read_value,
   output logic              stall,
   output logic              result_valid,
   output logic [31:0]       read_value
);

   rd_state_t         state_r;
   logic [1:0]        offset_r;
   logic [2:0]        type_r;
   logic [MEM_AW-1:0] waddr_r;
   logic [MEM_AW-1:0] hold_addr_r;
   logic [23:0]       low_r;

   logic              split_s;
   logic              accept_s;
   logic              result_valid_s;
   logic [63:0]       window_s;
   logic [31:0]       ext_s;

   // Decode current beat, request acceptance, memory address and extraction window.
   always_comb begin
      split_s        = (state_r == BEAT1) && is_split_load(type_r, offset_r);
      accept_s       = valid && instr_is_load && !split_s;
      result_valid_s = ((state_r == BEAT1) && !split_s) || (state_r == BEAT2);
      if (accept_s) begin
         mem_word_addr = long_addr[ADDR_W-1:2];
      end else if (split_s) begin
         mem_word_addr = waddr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
      end else begin
         mem_word_addr = hold_addr_r;
      end
      // Byte 0 of the window is never selected on a split beat, so it is zero-padded.
      if (state_r == BEAT2) begin
         window_s = {mem_read_value, low_r, 8'h00};
      end else begin
         window_s = {32'h00000000, mem_read_value};
      end
   end

   load_extract u_extract (
      .window    (window_s),
      .offset    (offset_r),
      .load_type (type_r),
      .result    (ext_s)
   );

   assign stall        = split_s;
   assign result_valid = result_valid_s;
   assign read_value   = result_valid_s ? ext_s : 32'h00000000;

   // Read FSM and request capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         offset_r    <= 2'b00;
         type_r      <= 3'b000;
         waddr_r     <= '0;
         hold_addr_r <= '0;
         low_r       <= 24'h000000;
      end else begin
         hold_addr_r <= mem_word_addr;
         case (state_r)
            IDLE, BEAT2: begin
               if (accept_s) begin
                  offset_r <= long_addr[1:0];
                  type_r   <= load_type;
                  waddr_r  <= long_addr[ADDR_W-1:2];
                  state_r  <= BEAT1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            BEAT1: begin
               if (split_s) begin
                  low_r    <= mem_read_value[31:8];
                  state_r  <= BEAT2;
               end else if (accept_s) begin
                  offset_r <= long_addr[1:0];
                  type_r   <= load_type;
                  waddr_r  <= long_addr[ADDR_W-1:2];
                  state_r  <= BEAT1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_read_interface.sv
// Self-checking bench: vector table, scoreboard on results, and multi-cycle corner sequences.
module tb_data_memory_read_interface;

   logic        clock;
   logic        reset;
   logic        valid;
   logic        instr_is_load;
   logic [31:0] long_addr;
   logic [2:0]  load_type;
   logic [29:0] mem_word_addr;
   logic [31:0] mem_read_value;
   logic        stall;
   logic        result_valid;
   logic [31:0] read_value;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [logic [29:0]];
   logic [31:0] sb_q [$];

   data_memory_read_interface #(.ADDR_W(32), .MEM_AW(30)) dut (
      .clock          (clock),
      .reset          (reset),
      .valid          (valid),
      .instr_is_load  (instr_is_load),
      .long_addr      (long_addr),
      .load_type      (load_type),
      .mem_word_addr  (mem_word_addr),
      .mem_read_value (mem_read_value),
      .stall          (stall),
      .result_valid   (result_valid),
      .read_value     (read_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h00000000;
   endfunction

   // Synchronous-read memory: data appears one cycle after its address.
   always @(posedge clock) mem_read_value <= mem_rd(mem_word_addr);

   // Byte-wise reference for a RISC-V load.
   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] lt);
      logic [31:0] a;
      logic [31:0] w;
      logic [7:0]  b [4];
      int          n;
      for (int i = 0; i < 4; i++) begin
         a = addr + 32'(i);
         w = mem_rd(a[31:2]);
         b[i] = w[8*a[1:0] +: 8];
      end
      case (lt)
         3'b000: n = 1;
         3'b100: n = 1;
         3'b001: n = 2;
         3'b101: n = 2;
         default: n = 4;
      endcase
      if (n == 1) return (lt == 3'b000) ? {{24{b[0][7]}}, b[0]} : {24'h000000, b[0]};
      if (n == 2) return (lt == 3'b001) ? {{16{b[1][7]}}, b[1], b[0]} : {16'h0000, b[1], b[0]};
      return {b[3], b[2], b[1], b[0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every result_valid cycle consumes one expected value.
   always @(negedge clock) begin
      if (!reset && result_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected actual=%h required=no_result t=%0t", read_value, $time);
         end else begin
            check("sb_value", read_value, sb_q.pop_front());
         end
      end
   end

   typedef struct {
      logic [29:0] wa;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] addr;
      logic [2:0]  lt;
      logic [31:0] exp;
      bit          split;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [29:0] nxt;
      vecs[0]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h103, 3'b000, 32'hFFFFFF80, 1'b0};
      vecs[1]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h103, 3'b100, 32'h00000080, 1'b0};
      vecs[2]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h102, 3'b001, 32'hFFFF80FF, 1'b0};
      vecs[3]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h100, 3'b101, 32'h00001234, 1'b0};
      vecs[4]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h100, 3'b010, 32'h80FF1234, 1'b0};
      vecs[5]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h100, 3'b011, 32'h80FF1234, 1'b0};
      vecs[6]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h100, 3'b111, 32'h80FF1234, 1'b0};
      vecs[7]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h101, 3'b001, 32'hFFFFFF12, 1'b0};
      vecs[8]  = '{30'h40, 32'h80FF1234, 32'h0, 32'h100, 3'b000, 32'h00000034, 1'b0};
      vecs[9]  = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h102, 3'b010, 32'h3344AABB, 1'b1};
      vecs[10] = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h101, 3'b010, 32'h44AABBCC, 1'b1};
      vecs[11] = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h103, 3'b010, 32'h223344AA, 1'b1};
      vecs[12] = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h103, 3'b001, 32'h000044AA, 1'b1};
      vecs[13] = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h103, 3'b101, 32'h000044AA, 1'b1};
      vecs[14] = '{30'h3FFFFFFF, 32'h12000000, 32'h00000085, 32'hFFFFFFFF, 3'b001, 32'hFFFF8512, 1'b1};
      vecs[15] = '{30'h40, 32'hAABBCCDD, 32'h11223344, 32'h101, 3'b110, 32'h44AABBCC, 1'b1};

      reset = 1'b1;
      valid = 1'b0;
      instr_is_load = 1'b0;
      long_addr = 32'h0;
      load_type = 3'b000;
      #1;
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_result_valid", {31'h0, result_valid}, 32'h0);
      check("rst_read_value", read_value, 32'h0);
      check("rst_addr_known", {31'h0, $isunknown(mem_word_addr)}, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #2;

      foreach (vecs[i]) begin
         mem.delete();
         mem[vecs[i].wa] = vecs[i].w0;
         nxt = vecs[i].wa + 30'd1;
         mem[nxt] = vecs[i].w1;
         valid = 1'b1;
         instr_is_load = 1'b1;
         long_addr = vecs[i].addr;
         load_type = vecs[i].lt;
         sb_q.push_back(vecs[i].exp);
         @(posedge clock); #1;
         valid = 1'b0;
         #1;
         if (vecs[i].split) begin
            check($sformatf("v%0d_t1_stall", i), {31'h0, stall}, 32'h1);
            check($sformatf("v%0d_t1_rv", i), {31'h0, result_valid}, 32'h0);
            check($sformatf("v%0d_t1_addr", i), {2'b00, mem_word_addr}, {2'b00, nxt});
            @(posedge clock); #2;
         end
         check($sformatf("v%0d_rv", i), {31'h0, result_valid}, 32'h1);
         check($sformatf("v%0d_value", i), read_value, vecs[i].exp);
         check($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
         @(posedge clock); #2;
      end

      // Back-to-back aligned words: one result per cycle, never stalled.
      mem.delete();
      for (int i = 0; i < 4; i++) mem[30'h40 + 30'(i)] = $urandom;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1;
         instr_is_load = 1'b1;
         long_addr = 32'h100 + 32'(4 * i);
         load_type = 3'b010;
         sb_q.push_back(ref_load(long_addr, load_type));
         @(posedge clock); #2;
         check($sformatf("b2b%0d_rv", i), {31'h0, result_valid}, 32'h1);
         check($sformatf("b2b%0d_stall", i), {31'h0, stall}, 32'h0);
      end
      valid = 1'b0;
      @(posedge clock); #2;
      check("b2b_idle_rv", {31'h0, result_valid}, 32'h0);

      // Request without the load flag is ignored.
      valid = 1'b1;
      instr_is_load = 1'b0;
      long_addr = 32'h102;
      load_type = 3'b010;
      @(posedge clock); #2;
      check("noload_rv", {31'h0, result_valid}, 32'h0);
      check("noload_stall", {31'h0, stall}, 32'h0);
      valid = 1'b0;
      @(posedge clock); #2;
      check("noload_rv2", {31'h0, result_valid}, 32'h0);

      // Reset during the first beat of a split load drops it.
      mem.delete();
      mem[30'h40] = 32'hAABBCCDD;
      mem[30'h41] = 32'h11223344;
      valid = 1'b1;
      instr_is_load = 1'b1;
      long_addr = 32'h102;
      load_type = 3'b010;
      @(posedge clock); #1;
      valid = 1'b0;
      #1;
      check("rsplit_stall_before", {31'h0, stall}, 32'h1);
      reset = 1'b1;
      #1;
      check("rsplit_stall", {31'h0, stall}, 32'h0);
      check("rsplit_rv", {31'h0, result_valid}, 32'h0);
      check("rsplit_value", read_value, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #2;
         check($sformatf("rsplit_after%0d_rv", i), {31'h0, result_valid}, 32'h0);
      end

      check("sb_empty", sb_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
